// File: rtl/button_repeat_pulser.sv
// Purpose: synchronise and debounce one raw push-button, emit a one-cycle move pulse on press plus auto-repeat while held.
// Latency: press first sampled at edge N -> o_pulse high after edge N+1+DEBOUNCE_CYCLES; repeats every HOLD/REPEAT cycles.
// Backpressure: none; pulses are fire-and-forget, the consumer must accept o_pulse on the cycle it is high.
module button_repeat_pulser #(
    parameter int DEBOUNCE_CYCLES = 250_000,
    parameter int HOLD_CYCLES     = 12_500_000,
    parameter int REPEAT_CYCLES   = 3_125_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_button,
    input  logic i_repeat_en,
    output logic o_pulse,
    output logic o_held
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic          r_s1;
    logic          r_s2;
    logic [DW-1:0] r_dcnt;
    logic          r_db;
    logic [TW-1:0] r_tmr;
    logic          r_pulse;
    state_t        r_state;

    logic          w_dbnc_expire;
    logic          w_db_rise;
    logic          w_db_fall;
    logic          w_hold_exp;
    logic          w_rep_exp;
    state_t        w_state_nxt;
    logic          w_pulse_nxt;
    logic [TW-1:0] w_tmr_nxt;

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_button;
            r_s2 <= r_s1;
        end
    end

    // The debounced level flips on the edge that completes a full run of disagreeing samples.
    // Rise/fall are derived from that flip condition so the FSM reacts on the same edge db changes.
    assign w_dbnc_expire = (r_s2 != r_db) && (r_dcnt == DB_LAST);
    assign w_db_rise     = w_dbnc_expire &&  r_s2;
    assign w_db_fall     = w_dbnc_expire && !r_s2;

    // Debounce counter: counts consecutive disagreeing samples, any agreement restarts it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dcnt <= '0;
            r_db   <= 1'b0;
        end else if (r_s2 == r_db) begin
            r_dcnt <= '0;
        end else if (w_dbnc_expire) begin
            r_db   <= r_s2;
            r_dcnt <= '0;
        end else begin
            r_dcnt <= r_dcnt + 1'b1;
        end
    end

    assign w_hold_exp = (r_tmr == HOLD_LAST);
    assign w_rep_exp  = (r_tmr == REP_LAST);

    // FSM state, repeat timer and pulse register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_tmr   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    // Next-state: a debounced release always wins over any timer expiry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_db_rise) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_db_fall)                      w_state_nxt = ST_IDLE;
                else if (w_hold_exp && i_repeat_en) w_state_nxt = ST_REPEAT;
            end
            ST_REPEAT: begin
                if (w_db_fall)         w_state_nxt = ST_IDLE;
                else if (!i_repeat_en) w_state_nxt = ST_HOLD;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: pulse and timer update. Leaving REPEAT for HOLD parks the timer at the hold
    // expiry value so re-enabling repeat fires on the very next edge.
    always_comb begin
        w_pulse_nxt = 1'b0;
        w_tmr_nxt   = r_tmr;
        case (r_state)
            ST_IDLE: begin
                if (w_db_rise) begin
                    w_pulse_nxt = 1'b1;
                    w_tmr_nxt   = '0;
                end
            end
            ST_HOLD: begin
                if (w_db_fall) begin
                    w_tmr_nxt = '0;
                end else if (w_hold_exp) begin
                    if (i_repeat_en) begin
                        w_pulse_nxt = 1'b1;
                        w_tmr_nxt   = '0;
                    end
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (w_db_fall) begin
                    w_tmr_nxt = '0;
                end else if (!i_repeat_en) begin
                    w_tmr_nxt = HOLD_LAST;
                end else if (w_rep_exp) begin
                    w_pulse_nxt = 1'b1;
                    w_tmr_nxt   = '0;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            default: begin
                w_tmr_nxt = '0;
            end
        endcase
    end

    assign o_pulse = r_pulse;
    assign o_held  = r_db;

endmodule

// File: tb/tb_button_repeat_pulser.sv
// Bench for button_repeat_pulser with DEBOUNCE=4, HOLD=10, REPEAT=3.
// Edge 0 is the reset edge of each scenario; edges are numbered from there.
// Outputs are logged 1 time unit after each rising edge into per-edge arrays.
module tb_button_repeat_pulser;

    logic clk;
    logic rst;
    logic i_button;
    logic i_repeat_en;
    logic o_pulse;
    logic o_held;

    button_repeat_pulser #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10),
        .REPEAT_CYCLES  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_button   (i_button),
        .i_repeat_en(i_repeat_en),
        .o_pulse    (o_pulse),
        .o_held     (o_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int e;
    int b2b;
    logic prev_pulse;
    logic pulse_log [0:511];
    logic held_log  [0:511];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            e++;
            if (e < 512) begin
                pulse_log[e] = o_pulse;
                held_log[e]  = o_held;
            end
            if (o_pulse === 1'b1 && prev_pulse === 1'b1) b2b++;
            prev_pulse = o_pulse;
        end
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 512; i++) begin
            pulse_log[i] = 1'b0;
            held_log[i]  = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        e = 0;
        prev_pulse = o_pulse;
        clear_logs();
    endtask

    function automatic int cnt_pulse(input int lo, input int hi);
        int c;
        c = 0;
        for (int i = lo; i <= hi; i++) if (pulse_log[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int cnt_held(input int lo, input int hi);
        int c;
        c = 0;
        for (int i = lo; i <= hi; i++) if (held_log[i] === 1'b1) c++;
        return c;
    endfunction

    int bl [10];
    int s;

    initial begin
        total = 0;
        bad = 0;
        b2b = 0;
        e = 0;
        rst = 1'b0;
        i_button = 1'b0;
        i_repeat_en = 1'b1;
        prev_pulse = 1'b0;

        // Reset state
        do_reset();
        chk("rst_pulse", {31'd0, o_pulse}, 32'd0);
        chk("rst_held",  {31'd0, o_held},  32'd0);

        // Clean press sampled at edge 10, held with repeat enabled
        run(9);
        i_button = 1'b1;
        run(25);
        chk("t1_cnt_1_34", cnt_pulse(1, 34), 5);
        chk("t1_p15", {31'd0, pulse_log[15]}, 32'd1);
        chk("t1_p25", {31'd0, pulse_log[25]}, 32'd1);
        chk("t1_p28", {31'd0, pulse_log[28]}, 32'd1);
        chk("t1_p31", {31'd0, pulse_log[31]}, 32'd1);
        chk("t1_p34", {31'd0, pulse_log[34]}, 32'd1);
        chk("t1_held14", {31'd0, held_log[14]}, 32'd0);
        chk("t1_held15", {31'd0, held_log[15]}, 32'd1);

        // Bounce: short high glitches are ignored, then a stable press gives one pulse
        i_button = 1'b0;
        do_reset();
        bl = '{1, 1, 2, 1, 3, 2, 3, 1, 1, 1};
        for (int i = 0; i < 10; i++) begin
            i_button = (i % 2 == 0);
            run(bl[i]);
        end
        run(3);
        chk("t2_bounce_pulse", cnt_pulse(1, e), 0);
        chk("t2_bounce_held",  cnt_held(1, e), 0);
        i_button = 1'b1;
        s = e + 1;
        run(12);
        chk("t2_stable_cnt", cnt_pulse(1, e), 1);
        chk("t2_stable_edge", {31'd0, pulse_log[s + 5]}, 32'd1);
        chk("t2_held_early", {31'd0, held_log[s + 4]}, 32'd0);

        // Release so the debounced fall lands on the hold expiry edge 25
        i_button = 1'b0;
        do_reset();
        run(9);
        i_button = 1'b1;
        run(10);
        i_button = 1'b0;
        run(15);
        chk("t3_cnt_1_34", cnt_pulse(1, 34), 1);
        chk("t3_p15", {31'd0, pulse_log[15]}, 32'd1);
        chk("t3_held24", {31'd0, held_log[24]}, 32'd1);
        chk("t3_held25", {31'd0, held_log[25]}, 32'd0);
        // Back in IDLE: a new press sampled at edge 40 gives a fresh pulse at 45
        run(5);
        i_button = 1'b1;
        run(10);
        chk("t3_repress_cnt", cnt_pulse(35, 49), 1);
        chk("t3_repress_p45", {31'd0, pulse_log[45]}, 32'd1);

        // Repeat disabled: one pulse over 100 held cycles, then enabling repeat
        i_button = 1'b0;
        i_repeat_en = 1'b0;
        do_reset();
        run(9);
        i_button = 1'b1;
        run(101);
        chk("t4_cnt_1_110", cnt_pulse(1, 110), 1);
        chk("t4_p15", {31'd0, pulse_log[15]}, 32'd1);
        i_repeat_en = 1'b1;
        run(8);
        chk("t4_p111", {31'd0, pulse_log[111]}, 32'd1);
        chk("t4_p114", {31'd0, pulse_log[114]}, 32'd1);
        chk("t4_p117", {31'd0, pulse_log[117]}, 32'd1);
        chk("t4_cnt_111_118", cnt_pulse(111, 118), 3);

        // Reset for one cycle mid-REPEAT with the button held
        i_button = 1'b0;
        do_reset();
        run(9);
        i_button = 1'b1;
        run(21);
        chk("t5_pre_cnt", cnt_pulse(1, 30), 3);
        rst = 1'b0;
        run(1);
        rst = 1'b1;
        chk("t5_rst_pulse", {31'd0, o_pulse}, 32'd0);
        chk("t5_rst_held",  {31'd0, o_held},  32'd0);
        run(10);
        chk("t5_quiet_32_36", cnt_pulse(32, 36), 0);
        chk("t5_p37", {31'd0, pulse_log[37]}, 32'd1);
        chk("t5_held36", {31'd0, held_log[36]}, 32'd0);
        chk("t5_held37", {31'd0, held_log[37]}, 32'd1);

        chk("no_back_to_back", b2b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
